// File: rtl/doc_hw_sensor_scan_checker_pkg.sv
// Shared types and constants for the sensor scan checker: channel response record,
// status vector, scan FSM states and the default range limits.
package doc_hw_sensor_scan_checker_pkg;

   localparam int P_CH_W             = 4;
   localparam int P_DATA_W           = 32;
   localparam int P_NO_CHANNELS_HW   = 9;
   localparam int P_NO_TEMP_CH_HW    = 5;
   localparam int P_MAX_TEMP_HW      = 60;
   localparam int P_MIN_TEMP_HW      = 0;
   localparam int P_V_MIN_MV         = 700;
   localparam int P_V_MAX_MV         = 1000;
   localparam int P_SCAN_TIMEOUT_CYC = 1024;

   typedef struct packed {
      logic [P_CH_W-1:0]   channel;
      logic [P_DATA_W-1:0] data;
   } channelData;

   typedef logic [P_NO_CHANNELS_HW-1:0] t_voltage_array;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      CHECK = 3'd3,
      NEXT  = 3'd4
   } t_scan_state;

endpackage

// File: rtl/doc_hw_sensor_scan_checker_range_check.sv
// Combinational inclusive window compare of one reading: signed degC limits for
// temperature channels, unsigned mV limits for voltage channels.
module doc_hw_sensor_scan_checker_range_check
   import doc_hw_sensor_scan_checker_pkg::*;
#(
   parameter int P_MIN_TEMP = P_MIN_TEMP_HW,
   parameter int P_MAX_TEMP = P_MAX_TEMP_HW,
   parameter int P_V_MIN    = P_V_MIN_MV,
   parameter int P_V_MAX    = P_V_MAX_MV
)(
   input  logic [P_DATA_W-1:0] i_data,
   input  logic                i_is_temp,
   output logic                o_in_range
);

   localparam logic signed [P_DATA_W-1:0] LP_T_MIN = P_MIN_TEMP;
   localparam logic signed [P_DATA_W-1:0] LP_T_MAX = P_MAX_TEMP;
   localparam logic        [P_DATA_W-1:0] LP_V_MIN = P_V_MIN;
   localparam logic        [P_DATA_W-1:0] LP_V_MAX = P_V_MAX;

   logic signed [P_DATA_W-1:0] w_temp;

   assign w_temp = $signed(i_data);

   always_comb begin
      if (i_is_temp) begin
         o_in_range = (w_temp >= LP_T_MIN) && (w_temp <= LP_T_MAX);
      end else begin
         o_in_range = (i_data >= LP_V_MIN) && (i_data <= LP_V_MAX);
      end
   end

endmodule

// File: rtl/doc_hw_sensor_scan_checker.sv
// Round-robin channel requester and range checker feeding the safety decision logic.
// Optional `DOC_HW_SCAN_DEBOUNCE_EN: a single out-of-range reading only raises a strike.
module doc_hw_sensor_scan_checker
   import doc_hw_sensor_scan_checker_pkg::*;
#(
   parameter int P_NO_CHANNELS = P_NO_CHANNELS_HW,
   parameter int P_NO_TEMP_CH  = P_NO_TEMP_CH_HW,
   parameter int P_MAX_TEMP    = P_MAX_TEMP_HW,
   parameter int P_MIN_TEMP    = P_MIN_TEMP_HW,
   parameter int P_TIMEOUT_CYC = P_SCAN_TIMEOUT_CYC
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     fault_clear,
   output logic                     req_valid,
   output logic [P_CH_W-1:0]        req_channel,
   input  logic                     req_ready,
   input  logic                     rsp_valid,
   input  logic [P_CH_W-1:0]        rsp_channel,
   input  logic [P_DATA_W-1:0]      rsp_data,
   output logic [P_NO_CHANNELS-1:0] status,
   output logic                     fault,
   output logic                     timeout_err,
   output logic                     scan_done
);

   localparam int                LP_TMR_W   = $clog2(P_TIMEOUT_CYC);
   localparam logic [LP_TMR_W-1:0] LP_TMR_LAST = LP_TMR_W'(P_TIMEOUT_CYC - 1);
   localparam logic [P_CH_W-1:0] LP_LAST_CH = P_CH_W'(P_NO_CHANNELS - 1);
   localparam logic [P_CH_W-1:0] LP_NO_TEMP = P_CH_W'(P_NO_TEMP_CH);

   t_scan_state                r_state;
   t_scan_state                w_next_state;
   logic [P_CH_W-1:0]          r_ch;
   logic [LP_TMR_W-1:0]        r_timer;
   logic [P_DATA_W-1:0]        r_data;
   logic                       r_pass;
   logic                       r_result_vld;
   logic [P_NO_CHANNELS-1:0]   r_status;
   logic                       r_fault;
   logic                       r_timeout_err;
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
   logic [P_NO_CHANNELS-1:0]   r_strike;
   logic [P_NO_CHANNELS-1:0]   w_strike_nxt;
`endif

   channelData                 w_rsp;
   logic                       w_match;
   logic                       w_timeout;
   logic                       w_last;
   logic                       w_is_temp;
   logic                       w_in_range;
   logic                       w_status_wr;
   logic                       w_status_val;
   logic                       w_fault_set;
   logic                       w_tmo_set;

   assign w_rsp     = '{channel: rsp_channel, data: rsp_data};
   assign w_match   = rsp_valid && (w_rsp.channel == r_ch);
   assign w_timeout = (r_timer == LP_TMR_LAST);
   assign w_last    = (r_ch == LP_LAST_CH);
   assign w_is_temp = (r_ch < LP_NO_TEMP);

   doc_hw_sensor_scan_checker_range_check #(
      .P_MIN_TEMP (P_MIN_TEMP),
      .P_MAX_TEMP (P_MAX_TEMP)
   ) u_range_check (
      .i_data     (r_data),
      .i_is_temp  (w_is_temp),
      .o_in_range (w_in_range)
   );

   // NOTE: state and datapath registers use non-blocking assignments so every
   // flop samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (enable) w_next_state = REQ;
         REQ:     if (req_ready) w_next_state = WAIT;
         WAIT: begin
            if (w_match)        w_next_state = CHECK;
            else if (w_timeout) w_next_state = NEXT;
         end
         CHECK:   w_next_state = NEXT;
         NEXT: begin
            if (!w_last || enable) w_next_state = REQ;
            else                   w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      req_valid   = (r_state == REQ);
      req_channel = r_ch;
      scan_done   = (r_state == NEXT) && w_last;
   end

   // Decide what the current cycle writes into status / fault / strike.
   // NOTE: every comb output gets a default first so no latch is inferred.
   always_comb begin
      w_status_wr  = 1'b0;
      w_status_val = 1'b0;
      w_fault_set  = 1'b0;
      w_tmo_set    = 1'b0;
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
      w_strike_nxt = r_strike;
`endif
      if ((r_state == WAIT) && !w_match && w_timeout) begin
         w_status_wr = 1'b1;
         w_fault_set = 1'b1;
         w_tmo_set   = 1'b1;
      end else if ((r_state == NEXT) && r_result_vld) begin
         if (r_pass) begin
            w_status_wr  = 1'b1;
            w_status_val = 1'b1;
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
            w_strike_nxt[r_ch] = 1'b0;
`endif
         end else begin
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
            if (r_strike[r_ch]) begin
               w_status_wr = 1'b1;
               w_fault_set = 1'b1;
            end else begin
               w_strike_nxt[r_ch] = 1'b1;
            end
`else
            w_status_wr = 1'b1;
            w_fault_set = 1'b1;
`endif
         end
      end
   end

   // NOTE: every register, including the status vector, has a defined reset value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ch          <= '0;
         r_timer       <= '0;
         r_data        <= '0;
         r_pass        <= 1'b0;
         r_result_vld  <= 1'b0;
         r_status      <= '0;
         r_fault       <= 1'b0;
         r_timeout_err <= 1'b0;
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
         r_strike      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE:  r_ch <= '0;
            REQ:   r_timer <= '0;
            WAIT: begin
               r_timer <= r_timer + 1'b1;
               if (w_match) r_data <= w_rsp.data;
            end
            CHECK: begin
               r_pass       <= w_in_range;
               r_result_vld <= 1'b1;
            end
            NEXT: begin
               r_result_vld <= 1'b0;
               r_ch         <= w_last ? '0 : r_ch + 1'b1;
            end
            default: r_ch <= '0;
         endcase

         if (w_status_wr) r_status[r_ch] <= w_status_val;

         // A new fault in the same cycle as fault_clear must survive.
         if (w_fault_set)      r_fault <= 1'b1;
         else if (fault_clear) r_fault <= 1'b0;

         if (w_tmo_set)        r_timeout_err <= 1'b1;
         else if (fault_clear) r_timeout_err <= 1'b0;
`ifdef DOC_HW_SCAN_DEBOUNCE_EN
         r_strike <= w_strike_nxt;
`endif
      end
   end

   assign status      = r_status;
   assign fault       = r_fault;
   assign timeout_err = r_timeout_err;

endmodule
